// File: rtl/enc_stage_ctrl_pkg.sv
// Shared definitions for the encoder stage controller.
// Holds the pipeline depth, the bit index of each stage inside the
// per-stage vectors, the LCU index width and the controller state encoding.
package enc_stage_ctrl_pkg;

  localparam int STG_NUM = 5;
  localparam int LCU_W   = 16;

  // Bit positions inside stg_start / stg_done / stg_valid vectors.
  localparam int STG_IME = 0;
  localparam int STG_FME = 1;
  localparam int STG_REC = 2;
  localparam int STG_DB  = 3;
  localparam int STG_EC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADV   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/enc_stage_ctrl.sv
// Encoder stage controller: sequences LCUs through a STG_NUM-deep
// pipeline of encoder stages. Each LCU period is ADV (advance pulse to the
// data pipeline), START (start pulse to every stage holding a real LCU) and
// WAIT (until every valid stage has reported done). After the last LCU has
// drained out of the final stage the frame-done pulse is produced.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   sys_start_i      frame start pulse (accepted only in IDLE, total != 0)
//   sys_total_lcu_i  LCUs in the frame, sampled on an accepted start
//   stg_done_i       per-stage done pulses
//   stg_start_o      per-stage start pulses
//   stg_valid_o      per-stage "holds a real LCU" flags
//   enc_done_o       pipeline advance pulse
//   lcu_idx_o        index of the LCU currently in stage 0
//   busy_o           frame in progress
//   sys_done_o       frame complete pulse
module enc_stage_ctrl #(
  parameter int STG_NUM = enc_stage_ctrl_pkg::STG_NUM
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 sys_start_i,
  input  logic [enc_stage_ctrl_pkg::LCU_W-1:0] sys_total_lcu_i,
  input  logic [STG_NUM-1:0]                   stg_done_i,
  output logic [STG_NUM-1:0]                   stg_start_o,
  output logic [STG_NUM-1:0]                   stg_valid_o,
  output logic                                 enc_done_o,
  output logic [enc_stage_ctrl_pkg::LCU_W-1:0] lcu_idx_o,
  output logic                                 busy_o,
  output logic                                 sys_done_o
);
  import enc_stage_ctrl_pkg::*;

  state_t             state_r, state_nxt;
  logic [LCU_W-1:0]   total_r, total_nxt;
  logic [LCU_W-1:0]   issued_r, issued_nxt;
  logic [LCU_W-1:0]   lcu_idx_nxt;
  logic [STG_NUM-1:0] valid_r, valid_nxt;
  logic [STG_NUM-1:0] done_r, done_nxt;
  logic [STG_NUM-1:0] valid_adv;
  logic [STG_NUM-1:0] stg_start_nxt;
  logic               issue;
  logic               start_ok;
  logic               all_done;

  // The counter stops at total, so it can never pass it or wrap.
  assign issue     = (issued_r < total_r);
  assign valid_adv = {valid_r[STG_NUM-2:0], issue};
  assign start_ok  = sys_start_i && (sys_total_lcu_i != '0);
  // Stages without a real LCU count as finished; same-cycle done pulses
  // are folded in so the advance is not delayed by the capture register.
  assign all_done  = &(done_r | stg_done_i | ~valid_r);

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      total_r     <= '0;
      issued_r    <= '0;
      valid_r     <= '0;
      done_r      <= '0;
      lcu_idx_o   <= '0;
      stg_start_o <= '0;
      enc_done_o  <= 1'b0;
      busy_o      <= 1'b0;
      sys_done_o  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      total_r     <= total_nxt;
      issued_r    <= issued_nxt;
      valid_r     <= valid_nxt;
      done_r      <= done_nxt;
      lcu_idx_o   <= lcu_idx_nxt;
      stg_start_o <= stg_start_nxt;
      enc_done_o  <= (state_nxt == ST_ADV);
      busy_o      <= (state_nxt != ST_IDLE);
      sys_done_o  <= (state_nxt == ST_DONE);
    end
  end

  assign stg_valid_o = valid_r;

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE:  if (start_ok) state_nxt = ST_ADV;
      ST_ADV:   state_nxt = (valid_adv == '0) ? ST_DONE : ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (all_done) state_nxt = ST_ADV;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    total_nxt     = total_r;
    issued_nxt    = issued_r;
    valid_nxt     = valid_r;
    done_nxt      = done_r;
    lcu_idx_nxt   = lcu_idx_o;
    stg_start_nxt = '0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok) begin
          total_nxt  = sys_total_lcu_i;
          issued_nxt = '0;
          valid_nxt  = '0;
          done_nxt   = '0;
        end
      end
      ST_ADV: begin
        valid_nxt = valid_adv;
        done_nxt  = '0;
        if (issue) begin
          lcu_idx_nxt = issued_r;
          issued_nxt  = issued_r + LCU_W'(1);
        end
        if (valid_adv != '0) stg_start_nxt = valid_adv;
      end
      ST_START, ST_WAIT: begin
        // Done from a stage with no real LCU is dropped here.
        done_nxt = done_r | (stg_done_i & valid_r);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_enc_stage_ctrl.sv
module tb_enc_stage_ctrl;

  logic        clk;
  logic        rstn;
  logic        sys_start_i;
  logic [15:0] sys_total_lcu_i;
  logic [4:0]  stg_done_i;
  logic [4:0]  stg_start_o;
  logic [4:0]  stg_valid_o;
  logic        enc_done_o;
  logic [15:0] lcu_idx_o;
  logic        busy_o;
  logic        sys_done_o;

  enc_stage_ctrl #(.STG_NUM(5)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .sys_start_i     (sys_start_i),
    .sys_total_lcu_i (sys_total_lcu_i),
    .stg_done_i      (stg_done_i),
    .stg_start_o     (stg_start_o),
    .stg_valid_o     (stg_valid_o),
    .enc_done_o      (enc_done_o),
    .lcu_idx_o       (lcu_idx_o),
    .busy_o          (busy_o),
    .sys_done_o      (sys_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Recorders updated on every step
  int          adv_cnt;
  int          sd_cnt;
  int          stall_adv;
  bit          sd_after_adv;
  bit          prev_enc;
  logic [4:0]  prev_start;
  logic [4:0]  vseq [$];
  logic [15:0] lseq [$];

  // Automatic done responder: each started stage reports done one cycle
  // after its start; stages outside auto_mask are delayed via d4.
  bit          auto_on;
  logic [4:0]  auto_mask;
  bit          wait4;
  int          d4;

  localparam logic [4:0] EXP_V [6] = '{5'b00001, 5'b00010, 5'b00100,
                                       5'b01000, 5'b10000, 5'b00000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    adv_cnt      = 0;
    sd_cnt       = 0;
    stall_adv    = 0;
    sd_after_adv = 0;
    prev_enc     = 0;
    prev_start   = '0;
    wait4        = 0;
    d4           = 0;
    vseq.delete();
    lseq.delete();
  endtask

  task automatic step();
    logic [4:0] d;
    @(posedge clk);
    #1;
    if (enc_done_o) begin
      adv_cnt++;
      if (wait4) stall_adv++;
    end
    if (prev_enc) vseq.push_back(stg_valid_o);
    if (stg_start_o[0]) lseq.push_back(lcu_idx_o);
    if (sys_done_o) begin
      sd_cnt++;
      sd_after_adv = prev_enc;
    end
    prev_enc = enc_done_o;
    if (auto_on) begin
      d = prev_start & auto_mask;
      if (stg_start_o[4] && !auto_mask[4]) begin
        wait4 = 1;
        d4    = 11;
      end else if (d4 > 0) begin
        d4--;
        if (d4 == 0) begin
          d[4]  = 1'b1;
          wait4 = 0;
        end
      end
      stg_done_i = d;
    end
    prev_start = stg_start_o;
  endtask

  task automatic run_to_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (sys_done_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_enc"},   32'(enc_done_o),  32'd0);
    chk({tag, "_busy"},  32'(busy_o),      32'd0);
    chk({tag, "_valid"}, 32'(stg_valid_o), 32'd0);
    chk({tag, "_start"}, 32'(stg_start_o), 32'd0);
    chk({tag, "_idx"},   32'(lcu_idx_o),   32'd0);
    chk({tag, "_sdone"}, 32'(sys_done_o),  32'd0);
  endtask

  initial begin
    bit ok;
    bit found;
    logic [31:0] obs;

    rstn            = 1'b0;
    sys_start_i     = 1'b0;
    sys_total_lcu_i = '0;
    stg_done_i      = '0;
    auto_on         = 0;
    auto_mask       = 5'b11111;
    clear_rec();

    // Reset state
    #12;
    chk_all_zero("rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    step();

    // total=1: first-LCU timing, then full drain
    clear_rec();
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd1;
    step();
    chk("t1_adv1_enc",   32'(enc_done_o),  32'd1);
    chk("t1_adv1_busy",  32'(busy_o),      32'd1);
    chk("t1_adv1_valid", 32'(stg_valid_o), 32'd0);
    sys_start_i = 1'b0;
    step();
    chk("t1_start",       32'(stg_start_o), 32'd1);
    chk("t1_start_valid", 32'(stg_valid_o), 32'd1);
    chk("t1_start_idx",   32'(lcu_idx_o),   32'd0);
    chk("t1_start_enc",   32'(enc_done_o),  32'd0);
    step();
    chk("t1_wait_enc",   32'(enc_done_o),  32'd0);
    chk("t1_wait_start", 32'(stg_start_o), 32'd0);
    stg_done_i = 5'b00001;
    step();
    chk("t1_adv2_enc", 32'(enc_done_o), 32'd1);
    stg_done_i = '0;
    auto_on    = 1;
    auto_mask  = 5'b11111;
    run_to_done(ok);
    chk("t1_timeout",   32'(ok),           32'd1);
    chk("t1_adv_cnt",   32'(adv_cnt),      32'd6);
    chk("t1_sd_timing", 32'(sd_after_adv), 32'd1);
    chk("t1_vseq_n",    32'(vseq.size()),  32'd6);
    for (int i = 0; i < 6; i++) begin
      obs = (i < vseq.size()) ? 32'(vseq[i]) : 32'hDEAD;
      chk($sformatf("t1_vseq%0d", i), obs, 32'(EXP_V[i]));
    end
    step();
    chk("t1_idle_busy", 32'(busy_o),     32'd0);
    chk("t1_idle_sd",   32'(sys_done_o), 32'd0);
    chk("t1_sd_cnt",    32'(sd_cnt),     32'd1);
    auto_on    = 0;
    stg_done_i = '0;

    // total=0 start is ignored
    clear_rec();
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd0;
    step();
    sys_start_i = 1'b0;
    step();
    chk("t0_busy", 32'(busy_o),     32'd0);
    chk("t0_enc",  32'(adv_cnt),    32'd0);
    chk("t0_idx",  32'(lcu_idx_o),  32'd0);

    // total=3, stage 4 done 10 cycles late; a start while busy is ignored
    clear_rec();
    auto_on         = 1;
    auto_mask       = 5'b01111;
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd3;
    step();
    sys_start_i = 1'b0;
    step();
    step();
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd9;
    step();
    chk("t3_busy_start_busy", 32'(busy_o), 32'd1);
    sys_start_i     = 1'b0;
    sys_total_lcu_i = 16'd0;
    run_to_done(ok);
    chk("t3_timeout",  32'(ok),          32'd1);
    chk("t3_adv_cnt",  32'(adv_cnt),     32'd8);
    chk("t3_stall",    32'(stall_adv),   32'd0);
    chk("t3_lseq_n",   32'(lseq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      obs = (i < lseq.size()) ? 32'(lseq[i]) : 32'hDEAD;
      chk($sformatf("t3_lseq%0d", i), obs, 32'(i));
    end
    step();
    auto_on    = 0;
    stg_done_i = '0;

    // Done on invalid stage 3 is ignored while only stage 0 is valid
    clear_rec();
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd1;
    step();
    sys_start_i = 1'b0;
    step();
    stg_done_i = 5'b01000;
    step();
    chk("t4_inv_wait1", 32'(enc_done_o), 32'd0);
    step();
    chk("t4_inv_wait2", 32'(enc_done_o), 32'd0);
    stg_done_i = 5'b00001;
    step();
    chk("t4_adv_after_s0", 32'(enc_done_o), 32'd1);
    stg_done_i = '0;
    auto_on    = 1;
    auto_mask  = 5'b11111;
    run_to_done(ok);
    chk("t4_timeout", 32'(ok),      32'd1);
    chk("t4_adv_cnt", 32'(adv_cnt), 32'd6);
    step();
    auto_on    = 0;
    stg_done_i = '0;

    // Done captured during START, simultaneous and repeated done pulses
    clear_rec();
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd2;
    step();
    sys_start_i = 1'b0;
    step();
    stg_done_i = 5'b00001;
    step();
    stg_done_i = '0;
    step();
    chk("t5_sticky_adv", 32'(enc_done_o), 32'd1);
    step();
    chk("t5_start2", 32'(stg_start_o), 32'd3);
    stg_done_i = 5'b00011;
    step();
    stg_done_i = 5'b00001;
    step();
    chk("t5_simul_adv", 32'(enc_done_o), 32'd1);
    stg_done_i = '0;
    prev_start = '0;
    auto_on    = 1;
    run_to_done(ok);
    chk("t5_timeout", 32'(ok),      32'd1);
    chk("t5_adv_cnt", 32'(adv_cnt), 32'd7);
    step();
    auto_on    = 0;
    stg_done_i = '0;

    // Reset mid-frame at LCU 2 of 4, then a clean 2-LCU frame
    clear_rec();
    auto_on         = 1;
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd4;
    step();
    sys_start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (stg_start_o[0] && lcu_idx_o == 16'd2) begin
        found = 1;
        break;
      end
    end
    chk("t6_reach_lcu2", 32'(found), 32'd1);
    auto_on    = 0;
    stg_done_i = '0;
    rstn       = 1'b0;
    #1;
    chk_all_zero("t6_async");
    @(posedge clk); #1;
    chk("t6_rst_sd", 32'(sys_done_o), 32'd0);
    rstn = 1'b1;
    step();
    chk("t6_post_busy", 32'(busy_o), 32'd0);
    chk("t6_no_sd",     32'(sd_cnt), 32'd0);
    clear_rec();
    auto_on         = 1;
    sys_start_i     = 1'b1;
    sys_total_lcu_i = 16'd2;
    step();
    sys_start_i = 1'b0;
    run_to_done(ok);
    chk("t6_timeout", 32'(ok),      32'd1);
    chk("t6_adv_cnt", 32'(adv_cnt), 32'd7);
    chk("t6_sd_cnt",  32'(sd_cnt),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_stage_ctrl.md
ENC_STAGE_CTRL -- requirements
Module: enc_stage_ctrl

Interface
REQ-001 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock.
- rstn, in, 1, reset, asynchronous, active-low.
- sys_start_i, in, 1, frame start pulse.
- sys_total_lcu_i, in, 16, LCUs in frame; sampled on accepted start.
- stg_done_i, in, 5, per-stage done pulses; bit0 posi/ime, 1 fme, 2 rec, 3 db, 4 ec.
- stg_start_o, out, 5, per-stage start pulses.
- stg_valid_o, out, 5, stage holds a real LCU.
- enc_done_o, out, 1, pipeline advance pulse; drives the data pipeline's enc_done_i.
- lcu_idx_o, out, 16, index of the LCU in stage 0.
- busy_o, out, 1, frame in progress.
- sys_done_o, out, 1, frame complete pulse.
REQ-002 SHALL have parameter STG_NUM, default 5, meaning number of pipeline stages.

Function
REQ-003 SHALL implement FSM states IDLE, ADV, START, WAIT, DONE, with all outputs registered.
REQ-004 IDLE: SHALL go to ADV when sys_start_i=1 and sys_total_lcu_i!=0; SHALL latch the total and clear the issued count, valid vector and done_r.
REQ-005 SHALL ignore sys_start_i when the total is 0 and in every non-IDLE state.
REQ-006 ADV: SHALL assert enc_done_o for exactly 1 cycle.
REQ-007 ADV: SHALL set issue=(issued<total) and update valid<={valid[3:0],issue}.
REQ-008 ADV: when issue=1, SHALL set lcu_idx_o<=issued and increment issued.
REQ-009 ADV: SHALL clear done_r.
REQ-010 ADV: SHALL go to DONE if the new valid vector is all-zero, otherwise to START.
REQ-011 START: SHALL set stg_start_o=valid for 1 cycle, then go to WAIT.
REQ-012 In START and WAIT, SHALL OR stg_done_i into sticky done_r for valid stages only; done for an invalid stage SHALL be ignored.
REQ-013 WAIT: SHALL go to ADV when (done_r | stg_done_i | ~valid) is all-ones, using same-cycle done inputs.
REQ-014 Minimum LCU period: 3 cycles (ADV, START, WAIT).
REQ-015 DONE: SHALL pulse sys_done_o for 1 cycle, then go to IDLE.
REQ-016 A frame of N LCUs SHALL produce exactly N+5 enc_done_o pulses.
REQ-017 LCU k SHALL be in stage s after advance pulse k+1+s.
REQ-018 busy_o SHALL be 1 in every state except IDLE.
REQ-019 Simultaneous done pulses from several stages SHALL all be captured.
REQ-020 A repeated done for the same stage within one period SHALL have no extra effect.
REQ-021 The issued counter SHALL be 16 bits, SHALL never exceed total, and SHALL not wrap.

Reset
REQ-022 On rstn=0, SHALL reset asynchronously to IDLE with every output 0 and all counters, valid and done_r 0.
REQ-023 Reset mid-frame SHALL abandon the frame; no sys_done_o pulse SHALL be produced.

Structure
REQ-024 A shared package SHALL hold STG_NUM, the stage bit indices, the state encoding and the LCU index width 16.
REQ-025 SHALL be a single module with no sub-module; the done tracker is inline logic.

Verification
REQ-026 Start with total=1, each valid stage done 1 cycle after its start: 6 enc_done pulses; stg_valid sequence 00001, 00010, 00100, 01000, 10000, 00000; sys_done 1 cycle after the 6th ADV.
REQ-027 Start at cycle 0, stage0 done at cycle 3: enc_done at cycles 1 and 4; stg_start_o=00001 at cycle 2.
REQ-028 total=3, stage 4 done 10 cycles late, others immediate: no ADV until the ec done arrives; 8 pulses in total; lcu_idx_o sequence 0, 1, 2.
REQ-029 Done on invalid stage 3 while only stage 0 is valid: ignored; advance waits for stage 0.
REQ-030 total=0 start, and a start while busy: both ignored; busy_o and the counters unchanged.
REQ-031 rstn low mid-frame at LCU 2 with total=4: all outputs 0 immediately; a new start with total=2 runs cleanly to 7 pulses.
